// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - HI/LO multiply/divide sequencer; optional madd via MDU_MADD_EN
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] dvd_mag, dvs_mag, dvs_safe, q_mag, r_mag, quot, rem;

  // Products: low 64 bits of the sign-extended operands give the signed result
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Divide on magnitudes, then restore signs; MIN/-1 falls out as 0x80000000 rem 0
  assign div_signed = (op == OP_DIV);
  assign a_neg      = div_signed & a[31];
  assign b_neg      = div_signed & b[31];
  assign dvd_mag    = a_neg ? -a : a;
  assign dvs_mag    = b_neg ? -b : b;
  assign dvs_safe   = (b == 32'd0) ? 32'd1 : dvs_mag;
  assign q_mag      = dvd_mag / dvs_safe;
  assign r_mag      = dvd_mag % dvs_safe;
  assign quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem        = a_neg ? -r_mag : r_mag;

`ifdef MDU_MADD_EN
  logic [63:0] madd_sum;
  assign madd_sum = {hi_q, lo_q} + prod_s;
`endif

  // Next-state: accept ops only in IDLE, count down and commit in RUN
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              count_d = 4'(MULT_CYCLES);
              state_d = S_RUN;
            end
            OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              count_d = 4'(MULT_CYCLES);
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              if (b == 32'd0) begin
                pend_hi_d = hi_q;
                pend_lo_d = lo_q;
              end else begin
                pend_hi_d = rem;
                pend_lo_d = quot;
              end
              count_d = 4'(DIV_CYCLES);
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
`ifdef MDU_MADD_EN
            OP_MADD: begin
              {pend_hi_d, pend_lo_d} = madd_sum;
              count_d = 4'(MULT_CYCLES);
              state_d = S_RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      S_RUN: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - scoreboard bench for mdu_sequencer
module tb_mdu_sequencer;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          nvec = 0;
  int          nerr = 0;

  mdu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model: computes the expected outcome, pushes it, then drives the op
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic signed [63:0] p;
    logic [63:0] acc;
    e.hi = m_hi; e.lo = m_lo; e.cyc = 0;
    p = $signed(x) * $signed(y);
    case (o)
      4'd1: begin {e.hi, e.lo} = p; e.cyc = MC; end
      4'd2: begin acc = {32'd0, x} * {32'd0, y}; {e.hi, e.lo} = acc; e.cyc = MC; end
      4'd3: begin
        e.cyc = DC;
        if (y != 0) begin
          if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
            e.lo = 32'h80000000; e.hi = 32'd0;
          end else begin
            e.lo = $signed(x) / $signed(y);
            e.hi = $signed(x) % $signed(y);
          end
        end
      end
      4'd4: begin e.cyc = DC; if (y != 0) begin e.lo = x / y; e.hi = x % y; end end
      4'd5: e.hi = x;
      4'd6: e.lo = x;
`ifdef MDU_MADD_EN
      4'd7: begin acc = {m_hi, m_lo} + p; {e.hi, e.lo} = acc; e.cyc = MC; end
`endif
      default: ;
    endcase
    m_hi = e.hi; m_lo = e.lo;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0; op = 4'd0;
  endtask

  // Counts busy cycles until the first idle cycle; -1 if it never goes idle
  task automatic wait_idle(output int c);
    c = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) return;
      c++;
    end
    c = -1;
  endtask

  task automatic test_reset();
    #1;
    nvec += 3;
    if (busy !== 1'b0)   begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (hi !== 32'd0)    begin nerr++; $display("FAIL reset_hi: got %h want 0", hi); end
    if (lo !== 32'd0)    begin nerr++; $display("FAIL reset_lo: got %h want 0", lo); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_directed();
    logic [3:0]  t_op[11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd3, 4'd5, 4'd6, 4'd0, 4'd9, 4'd3, 4'd4};
    logic [31:0] t_a[11]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000,
                              32'h12345678, 32'hCAFEF00D, 32'd1, 32'd1, 32'd7, 32'hFFFFFFFF};
    logic [31:0] t_b[11]  = '{32'd2, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFF,
                              32'd0, 32'd0, 32'd1, 32'd1, 32'hFFFFFFFE, 32'd16};
    exp_t e;
    int c;
    for (int i = 0; i < 11; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      wait_idle(c);
      e = sb.pop_front();
      nvec += 3;
      if (c !== e.cyc) begin nerr++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, c, e.cyc); end
      if (hi !== e.hi) begin nerr++; $display("FAIL dir%0d_hi: got %h want %h", i, hi, e.hi); end
      if (lo !== e.lo) begin nerr++; $display("FAIL dir%0d_lo: got %h want %h", i, lo, e.lo); end
    end
  endtask

  task automatic test_random();
    exp_t e;
    int c;
    logic [3:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 12; i++) begin
      o = 4'($urandom_range(1, 4));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      issue(o, x, y);
      wait_idle(c);
      e = sb.pop_front();
      nvec += 3;
      if (c !== e.cyc) begin nerr++; $display("FAIL rnd%0d_busy_cycles op%0d: got %0d want %0d", i, o, c, e.cyc); end
      if (hi !== e.hi) begin nerr++; $display("FAIL rnd%0d_hi op%0d a=%h b=%h: got %h want %h", i, o, x, y, hi, e.hi); end
      if (lo !== e.lo) begin nerr++; $display("FAIL rnd%0d_lo op%0d a=%h b=%h: got %h want %h", i, o, x, y, lo, e.lo); end
    end
  endtask

  task automatic test_start_while_busy();
    exp_t e;
    int c;
    // mtlo during the run must be dropped
    issue(4'd5, 32'd0, 32'd0);
    void'(sb.pop_front());
    wait_idle(c);
    issue(4'd1, 32'd3, 32'd4);
    @(negedge clk);
    start = 1'b1; op = 4'd6; a = 32'hDEADBEEF;
    @(posedge clk);
    #1 start = 1'b0; op = 4'd0;
    wait_idle(c);
    c++;
    e = sb.pop_front();
    nvec += 3;
    if (c !== MC)    begin nerr++; $display("FAIL ignore_busy_cycles: got %0d want %0d", c, MC); end
    if (hi !== e.hi) begin nerr++; $display("FAIL ignore_hi: got %h want %h", hi, e.hi); end
    if (lo !== e.lo) begin nerr++; $display("FAIL ignore_lo: got %h want %h", lo, e.lo); end
    // mthi on the commit edge must be dropped too
    issue(4'd1, 32'd5, 32'd6);
    for (int i = 0; i < MC; i++) @(negedge clk);
    start = 1'b1; op = 4'd5; a = 32'hAAAA5555;
    @(posedge clk);
    #1 start = 1'b0; op = 4'd0;
    @(negedge clk);
    e = sb.pop_front();
    nvec += 3;
    if (busy !== 1'b0) begin nerr++; $display("FAIL commit_edge_busy: got %b want 0", busy); end
    if (hi !== e.hi)   begin nerr++; $display("FAIL commit_edge_hi: got %h want %h", hi, e.hi); end
    if (lo !== e.lo)   begin nerr++; $display("FAIL commit_edge_lo: got %h want %h", lo, e.lo); end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int c;
    issue(4'd5, 32'h11112222, 32'd0);
    void'(sb.pop_front());
    wait_idle(c);
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    void'(sb.pop_front());
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    nvec += 3;
    if (busy !== 1'b0)   begin nerr++; $display("FAIL midreset_busy: got %b want 0", busy); end
    if (hi !== 32'd0)    begin nerr++; $display("FAIL midreset_hi: got %h want 0", hi); end
    if (lo !== 32'd0)    begin nerr++; $display("FAIL midreset_lo: got %h want 0", lo); end
    @(negedge clk);
    reset = 1'b0;
    repeat (DC + 2) @(negedge clk);
    nvec += 2;
    if (busy !== 1'b0)        begin nerr++; $display("FAIL no_late_commit_busy: got %b want 0", busy); end
    if ({hi, lo} !== 64'd0)   begin nerr++; $display("FAIL no_late_commit_hilo: got %h want 0", {hi, lo}); end
    issue(4'd1, 32'd2, 32'd3);
    wait_idle(c);
    e = sb.pop_front();
    nvec += 3;
    if (c !== e.cyc) begin nerr++; $display("FAIL after_reset_busy_cycles: got %0d want %0d", c, e.cyc); end
    if (hi !== e.hi) begin nerr++; $display("FAIL after_reset_hi: got %h want %h", hi, e.hi); end
    if (lo !== e.lo) begin nerr++; $display("FAIL after_reset_lo: got %h want %h", lo, e.lo); end
  endtask

  task automatic test_madd();
    exp_t e;
    int c;
    issue(4'd5, 32'd0, 32'd0);
    void'(sb.pop_front());
    wait_idle(c);
    issue(4'd6, 32'hFFFFFFFF, 32'd0);
    void'(sb.pop_front());
    wait_idle(c);
    issue(4'd7, 32'd1, 32'd1);
    wait_idle(c);
    e = sb.pop_front();
    nvec += 3;
    if (c !== e.cyc) begin nerr++; $display("FAIL madd_busy_cycles: got %0d want %0d", c, e.cyc); end
    if (hi !== e.hi) begin nerr++; $display("FAIL madd_hi: got %h want %h", hi, e.hi); end
    if (lo !== e.lo) begin nerr++; $display("FAIL madd_lo: got %h want %h", lo, e.lo); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_reset_mid_run();
    test_madd();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multiply/divide unit for the EX stage of the five-stage pipeline. It owns the HI/LO register pair, runs multi-cycle multiply and divide operations with fixed latencies, and drives the `busy` flag. The hazard unit combines `busy` with the decoder's `start` to stall any HI/LO-touching instruction in D. Results are computed when the operation is accepted, held in pending registers, and committed to HI/LO when the latency counter expires.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (and madd when enabled); legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1..15.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `start`  in  1: qualifies `op` for one cycle; EX-stage instruction is an MDU op.
- `op`  in  4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd; 8..15 reserved.
- `a`  in  32: rs operand (forwarded value).
- `b`  in  32: rt operand (forwarded value).
- `busy`  out  1: multi-cycle operation in flight.
- `hi`  out  32: HI register, feeds mfhi.
- `lo`  out  32: LO register, feeds mflo.

## Operation
- FSM states: IDLE (count==0) and RUN (count!=0). `busy` = RUN, driven from a register with no combinational path from `start`.
- IDLE, `start`, op 1/2/7: pending {HI,LO} latched from the 64-bit product; count loaded with `MULT_CYCLES`; go to RUN.
- IDLE, `start`, op 3/4: pending LO = quotient, pending HI = remainder; count loaded with `DIV_CYCLES`; go to RUN.
- IDLE, `start`, op 5/6: `hi`/`lo` written with `a` on that edge; no RUN; `busy` stays 0.
- RUN: count decrements each edge. On the edge where the count goes 1→0, HI/LO take the pending values and the FSM returns to IDLE.
- Arithmetic rules:
  - mult: signed 32×32→64. multu: unsigned.
  - div: signed, quotient truncates toward zero, remainder takes the sign of the dividend. divu: unsigned.
  - 0x80000000 div 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
  - Divide by zero: runs the full `DIV_CYCLES`, then leaves HI/LO unchanged (pending is loaded from current HI/LO).
- Boundary conditions:
  - `start` while RUN: ignored entirely, including mthi/mtlo. The hazard unit guarantees this does not occur; the bench checks that state is not corrupted.
  - `start` on the same edge as a 1→0 commit: the FSM is still RUN, so `start` is ignored.
  - op 0 or 8..15 with `start`: no-op.
  - `reset` mid-RUN: count = 0, pending discarded, `hi` = `lo` = 0, `busy` = 0.

## Timing
- Reset values: `busy` = 0, `hi` = 0, `lo` = 0, count = 0, pending = 0.
- `start` sampled at edge T:
  - `busy` = 1 for cycles T+1 .. T+N, with N the latency.
  - New HI/LO visible in cycle T+N+1, the first cycle with `busy` = 0.
  - The next `start` is accepted at edge T+N+1 at the earliest.
- mthi/mtlo sampled at edge T: value visible in cycle T+1; zero busy cycles.
- `hi`/`lo` outputs are registers; mfhi reads them directly. The hazard unit stalls the reader while `start` or `busy` is high.

## Configuration
- `MDU_MADD_EN` defined: op 7 (madd) is accepted. {HI,LO} = {HI,LO} + signed(a)×signed(b), modulo 2^64. The accumulate base is the HI/LO value at acceptance. Latency is `MULT_CYCLES`.
- `MDU_MADD_EN` undefined: op 7 is a reserved no-op; no accumulate adder is synthesized.

## Test plan
- mult a=0xFFFFFFFF, b=2 → `busy` high 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
- multu a=0xFFFFFFFF, b=2 → HI = 0x00000001, LO = 0xFFFFFFFE after 5 busy cycles.
- div a=0xFFFFFFF9 (−7), b=2 → `busy` 10 cycles; then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. divu 7/0 → HI/LO unchanged after 10 cycles.
- mthi a=0x12345678 → `hi` = 0x12345678 next cycle, `busy` never asserts. Then mult 3×4 with a mtlo `start` at busy cycle 2 → mtlo ignored; final LO = 12, HI = 0.
- `reset` pulsed asynchronously mid-cycle during div busy cycle 4 → `busy`, `hi`, `lo` drop to 0 immediately, no later commit. A following mult 2×3 → LO = 6.
- With `MDU_MADD_EN`: HI = 0, LO = 0xFFFFFFFF, madd 1×1 → HI = 1, LO = 0 after 5 cycles. Without the macro: the same stimulus leaves HI/LO unchanged and `busy` = 0.
